factorial_bcd_conv: RTL
=======================

# factorial_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the factorial block. It captures each 46-bit factorial result and converts it to packed decimal digits with the shift-and-add-3 (double-dabble) algorithm, one bit per cycle. It also reports the count of significant digits, so a display or UART formatter can print the result without leading zeros.

## Interface
Parameters:
- DATA_W, 46, width of the binary input (holds up to 15! and all-ones).
- DIGITS, 14, BCD digits produced. Must equal ceil(DATA_W·log10 2); 14 for 46.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  binary value, normally the factorial result.
- in_valid  input  1  level; a rising edge requests a conversion.
- out_bcd  output  4·DIGITS  packed BCD; digit 0 = bits [3:0], least significant.
- out_ndigits  output  4  significant digit count, 1..DIGITS.
- out_valid  output  1  result valid; held until the next accepted request.
- out_busy  output  1  conversion in progress.
- out_dropped  output  1  one-cycle pulse: a request was ignored while busy.

## Operation
- Rising-edge detect: in_valid_q registers in_valid every cycle; request = in_valid & ~in_valid_q.
- A level held high does not retrigger.
- FSM states: IDLE, CONV, FINISH.
- IDLE + request:
  - load shift register = in_data, BCD accumulator = 0, bit counter = DATA_W−1;
  - out_busy←1, out_valid←0;
  - go to CONV.
- CONV, each cycle:
  - every BCD digit ≥5 gets +3 (combinational);
  - then {bcd, shift} shifts left by 1 and the counter decrements;
  - after the iteration with counter = 0, go to FINISH.
- FINISH, one cycle:
  - out_bcd←accumulator;
  - out_ndigits←index of the highest nonzero digit + 1, or 1 if the value is zero;
  - out_valid←1, out_busy←0;
  - go to IDLE.
- Request while in CONV or FINISH:
  - the request is ignored and out_dropped pulses for one cycle;
  - the in-flight conversion is unaffected.
- Arithmetic:
  - the adjusted digit is 4 bits wide with no carry out, since a digit ≥5 plus 3 never exceeds 12 before the shift;
  - for any DATA_W-bit input the accumulator never overflows DIGITS digits.
- out_bcd and out_ndigits hold their last values until the next FINISH. They are not cleared at IDLE.

## Timing
- Reset values:
  - out_bcd=0, out_ndigits=0, out_valid=0, out_busy=0, out_dropped=0;
  - state=IDLE, in_valid_q=0, internal registers 0.
- Latency: if the request is accepted at edge E0, CONV runs on E1..E_DATA_W. out_valid rises at E_(DATA_W+1), which is edge 47 by default.
- Throughput: one conversion per DATA_W+2 cycles at best (CONV plus FINISH plus IDLE).
- out_busy is high from E0 through E_DATA_W and falls at the same edge that out_valid rises.
- A request arriving in the IDLE cycle right after FINISH is accepted.
- Reset mid-conversion: the conversion aborts immediately and all outputs return to reset values.
- in_valid held high through reset release counts as a rising edge on the first clocked cycle, because in_valid_q=0. This is intended: a result pending from upstream is captured.
- Upstream compatibility: the factorial block's out_valid rises once per result and stays high, so each result is converted exactly once.

## Structure
- Shared package factorial_pkg:
  - localparams FACT_DATA_W=46 and FACT_BCD_DIGITS=14;
  - typedef enum logic [1:0] bcd_state_t {IDLE, CONV, FINISH};
  - the upstream block's result width is also taken from this package.
- One sub-module, bcd_digit_adjust: 4-bit in, 4-bit out, +3 when ≥5. It is instantiated DIGITS times via generate.
- Leading-digit scan is a combinational priority loop feeding the FINISH register.

## Test plan
- Reset, then in_data=0 with an in_valid rising edge → after 47 edges, out_bcd=0, out_ndigits=1, out_valid=1, out_busy=0.
- in_data=120 (5!) → out_bcd=0x120, out_ndigits=3, and out_valid rises exactly 47 edges after acceptance.
- in_data=1307674368000 (15!) → out_bcd=0x01307674368000, out_ndigits=13; also chained end to end behind the factorial block with in_data=15.
- in_data=2^46−1 → out_bcd=0x70368744177663, out_ndigits=14; in_valid held high afterwards causes no second conversion.
- Second rising edge 10 cycles into a conversion of 720 → out_dropped pulses once, result 0x720, out_ndigits=3, no second conversion.
- Reset asserted at cycle 20 of a conversion → all outputs 0 asynchronously. After release with in_valid still high and in_data=24, the bench sees a new conversion giving out_bcd=0x24.

Source files
------------

// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial datapath and its BCD output converter.
//   FACT_DATA_W     : width of a factorial result (holds 15! and all-ones)
//   FACT_BCD_DIGITS : decimal digits needed to print any FACT_DATA_W-bit value
//   bcd_state_t     : control states of the binary-to-BCD converter
package factorial_pkg;

  localparam int FACT_DATA_W     = 46;
  localparam int FACT_BCD_DIGITS = 14;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction cell: adds 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
//   digit_in  : current 4-bit BCD digit
//   digit_out : corrected digit (never exceeds 12, so no carry out is needed)
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/factorial_bcd_conv.sv
// Sequential binary-to-BCD converter placed behind the factorial block.
// A rising edge on in_valid captures in_data and converts it one bit per cycle
// with shift-and-add-3, then reports packed BCD plus the significant digit count.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   in_data      : binary value to convert
//   in_valid     : level; only its rising edge requests a conversion
//   out_bcd      : packed BCD result, digit 0 in bits [3:0]
//   out_ndigits  : number of significant digits (1 for a zero result)
//   out_valid    : result valid, held until the next accepted request
//   out_busy     : conversion in progress
//   out_dropped  : one-cycle pulse when a request arrives while busy
module factorial_bcd_conv
  import factorial_pkg::*;
#(
  parameter int DATA_W = FACT_DATA_W,
  parameter int DIGITS = FACT_BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [3:0]            out_ndigits,
  output logic                  out_valid,
  output logic                  out_busy,
  output logic                  out_dropped
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W - 1);

  bcd_state_t            state_q, state_d;
  logic                  in_valid_q;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   out_bcd_q, out_bcd_d;
  logic [3:0]            out_ndigits_q, out_ndigits_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_busy_q, out_busy_d;
  logic                  out_dropped_q, out_dropped_d;

  logic                  request;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [3:0]            lead_ndigits;

  assign request = in_valid & ~in_valid_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (bcd_q[4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

  // Highest nonzero digit wins; a zero accumulator still prints one digit.
  always_comb begin
    lead_ndigits = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        lead_ndigits = 4'(i + 1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    out_bcd_d     = out_bcd_q;
    out_ndigits_d = out_ndigits_q;
    out_valid_d   = out_valid_q;
    out_busy_d    = out_busy_q;
    out_dropped_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (request) begin
          shift_d     = in_data;
          bcd_d       = '0;
          cnt_d       = CNT_INIT;
          out_busy_d  = 1'b1;
          out_valid_d = 1'b0;
          state_d     = CONV;
        end
      end
      CONV: begin
        // Adjusted digits and the shift register move left as one long word.
        bcd_d   = {bcd_adj[4*DIGITS-2:0], shift_q[DATA_W-1]};
        shift_d = {shift_q[DATA_W-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FINISH;
        end
        out_dropped_d = request;
      end
      FINISH: begin
        out_bcd_d     = bcd_q;
        out_ndigits_d = lead_ndigits;
        out_valid_d   = 1'b1;
        out_busy_d    = 1'b0;
        state_d       = IDLE;
        out_dropped_d = request;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      in_valid_q    <= 1'b0;
      shift_q       <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      out_bcd_q     <= '0;
      out_ndigits_q <= '0;
      out_valid_q   <= 1'b0;
      out_busy_q    <= 1'b0;
      out_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_valid_q    <= in_valid;
      shift_q       <= shift_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      out_bcd_q     <= out_bcd_d;
      out_ndigits_q <= out_ndigits_d;
      out_valid_q   <= out_valid_d;
      out_busy_q    <= out_busy_d;
      out_dropped_q <= out_dropped_d;
    end
  end

  assign out_bcd     = out_bcd_q;
  assign out_ndigits = out_ndigits_q;
  assign out_valid   = out_valid_q;
  assign out_busy    = out_busy_q;
  assign out_dropped = out_dropped_q;

endmodule
